// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction fetch stage with a prefetch FIFO and redirect flush
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   code_mem [DEPTH];

    logic [CW-1:0] occupancy;
    logic          has_data;
    logic          push;
    logic          pop;

    // Credit counts the outstanding response so it always has a free slot; same-cycle pops are ignored.
    assign occupancy = count + CW'(inflight);
    assign imem_req  = !rst && !redirect && (occupancy < DEPTH_C);
    assign imem_addr = fetch_pc;

    assign has_data = (count != '0);
    assign push     = inflight && !redirect;
    assign pop      = has_data && instr_ready && !redirect;

    // Head is read show-ahead; outputs are forced idle while reset is held.
    assign instr_valid = !rst && has_data;
    assign instr_code  = instr_valid ? code_mem[rd_ptr] : NOP;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

    // Program counter, in-flight tracking, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: capture the returning word together with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            code_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule
